// File: rtl/data_memory_unit.sv
// Data memory for the pipelined ARM32 core.
// Takes address, store data and control from the Memory-stage register and
// returns load data registered into Writeback. Word and byte access, flags
// misaligned word accesses, and zeroes the whole array after every reset
// before any access is honoured.
module data_memory_unit #(
    parameter int DEPTH_LOG2 = 6,
    parameter int CNT_W      = 16
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             MemReadM,
    input  logic             MemWriteM,
    input  logic             ByteM,
    input  logic [31:0]      ALUOutM,
    input  logic [31:0]      WriteDataM,
    output logic [31:0]      ReadDataW,
    output logic             Ready,
    output logic             AlignFault,
    output logic [CNT_W-1:0] StoreCount
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DEPTH_LOG2-1:0] clr_ptr;

    // Byte-addressable storage: mem[word][lane], lane 0 is bits [7:0].
    logic [3:0][7:0]       mem [DEPTH];

    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            lane;
    logic                  run;
    logic                  misaligned;
    logic                  rd_en;
    logic                  wr_en;
    logic                  word_access;
    logic [3:0][7:0]       rd_word;
    logic [31:0]           load_data;

    // Address bits above the array simply wrap; they are intentionally dropped.
    logic                  unused_addr;
    assign unused_addr = ^ALUOutM[31:DEPTH_LOG2+2];

    // Saturating increment for the store counter: sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Address decode and access qualification; nothing is honoured while clearing.
    always_comb begin
        word_idx    = ALUOutM[DEPTH_LOG2+1:2];
        lane        = ALUOutM[1:0];
        run         = (state == RUN);
        misaligned  = !ByteM && (lane != 2'd0);
        rd_en       = run && MemReadM;
        wr_en       = run && MemWriteM && !misaligned;
        word_access = run && !ByteM && (MemReadM || MemWriteM);
        rd_word     = mem[word_idx];
        load_data   = ByteM ? {24'd0, rd_word[lane]} : rd_word;
    end

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Leave CLEAR on the edge that zeroes the last word.
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (&clr_ptr) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = CLEAR;
        endcase
    end

    // Clear pointer walks every word once per clear sequence.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end
    end

    // Array write port: clear writes zeros, stores write a word or a single lane.
    always_ff @(posedge CLOCK_50) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (wr_en) begin
            if (ByteM) begin
                mem[word_idx][lane] <= WriteDataM[7:0];
            end else begin
                mem[word_idx] <= WriteDataM;
            end
        end
    end

    // Registered load data (read-before-write), fault pulse and store counter.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ReadDataW  <= '0;
            AlignFault <= 1'b0;
            StoreCount <= '0;
        end else begin
            if (rd_en) begin
                ReadDataW <= load_data;
            end
            AlignFault <= word_access && (lane != 2'd0);
            if (wr_en) begin
                StoreCount <= sat_inc(StoreCount);
            end
        end
    end

    assign Ready = (state == RUN);

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit.
// Counter width is reduced so the saturation boundary is reachable quickly.
module tb_data_memory_unit;

    localparam int DEPTH_LOG2 = 6;
    localparam int CNT_W      = 4;

    logic             CLOCK_50 = 1'b0;
    logic             RESET_N;
    logic             MemReadM;
    logic             MemWriteM;
    logic             ByteM;
    logic [31:0]      ALUOutM;
    logic [31:0]      WriteDataM;
    logic [31:0]      ReadDataW;
    logic             Ready;
    logic             AlignFault;
    logic [CNT_W-1:0] StoreCount;

    int checks = 0;
    int fails  = 0;

    data_memory_unit #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .CNT_W     (CNT_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .MemReadM  (MemReadM),
        .MemWriteM (MemWriteM),
        .ByteM     (ByteM),
        .ALUOutM   (ALUOutM),
        .WriteDataM(WriteDataM),
        .ReadDataW (ReadDataW),
        .Ready     (Ready),
        .AlignFault(AlignFault),
        .StoreCount(StoreCount)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // One access cycle: drive, take the edge, sample 1 time unit later, go idle.
    task automatic access(input logic rd, input logic wr, input logic bt,
                          input logic [31:0] addr, input logic [31:0] data);
        MemReadM   = rd;
        MemWriteM  = wr;
        ByteM      = bt;
        ALUOutM    = addr;
        WriteDataM = data;
        @(posedge CLOCK_50);
        #1;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        ByteM      = 1'b0;
    endtask

    task automatic idle();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic test_reset();
        int n;
        RESET_N = 1'b0;
        MemReadM = 1'b0; MemWriteM = 1'b0; ByteM = 1'b0;
        ALUOutM = '0; WriteDataM = '0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL rst_rdata: got %h want 00000000", ReadDataW); end
        checks++; if (Ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", Ready); end
        checks++; if (AlignFault !== 1'b0) begin fails++; $display("FAIL rst_fault: got %b want 0", AlignFault); end
        checks++; if (StoreCount !== 4'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", StoreCount); end
        RESET_N = 1'b1;
        n = 0;
        while (Ready !== 1'b1 && n < 200) begin
            idle();
            n++;
        end
        checks++; if (n != 64) begin fails++; $display("FAIL clear_cycles: got %0d want 64", n); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_003C, 32'd0);
        checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL clear_load: got %h want 00000000", ReadDataW); end
    endtask

    task automatic test_word();
        access(1'b0, 1'b1, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF);
        checks++; if (StoreCount !== 4'd1) begin fails++; $display("FAIL str_count: got %0d want 1", StoreCount); end
        checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL str_no_load: got %h want 00000000", ReadDataW); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'd0);
        checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ldr_word: got %h want deadbeef", ReadDataW); end
        checks++; if (AlignFault !== 1'b0) begin fails++; $display("FAIL ldr_fault: got %b want 0", AlignFault); end
        idle();
        checks++; if (ReadDataW !== 32'hDEAD_BEEF) begin fails++; $display("FAIL ldr_hold: got %h want deadbeef", ReadDataW); end
    endtask

    task automatic test_byte();
        access(1'b0, 1'b1, 1'b1, 32'h0000_0009, 32'hFFFF_FF5A);
        checks++; if (StoreCount !== 4'd2) begin fails++; $display("FAIL strb_count: got %0d want 2", StoreCount); end
        checks++; if (AlignFault !== 1'b0) begin fails++; $display("FAIL strb_fault: got %b want 0", AlignFault); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_0008, 32'd0);
        checks++; if (ReadDataW !== 32'hDEAD_5AEF) begin fails++; $display("FAIL strb_merge: got %h want dead5aef", ReadDataW); end
        access(1'b1, 1'b0, 1'b1, 32'h0000_000B, 32'd0);
        checks++; if (ReadDataW !== 32'h0000_00DE) begin fails++; $display("FAIL ldrb_lane3: got %h want 000000de", ReadDataW); end
        access(1'b1, 1'b0, 1'b1, 32'h0000_0008, 32'd0);
        checks++; if (ReadDataW !== 32'h0000_00EF) begin fails++; $display("FAIL ldrb_lane0: got %h want 000000ef", ReadDataW); end
    endtask

    task automatic test_misaligned();
        access(1'b0, 1'b1, 1'b0, 32'h0000_0006, 32'h1111_1111);
        checks++; if (AlignFault !== 1'b1) begin fails++; $display("FAIL mis_str_fault: got %b want 1", AlignFault); end
        checks++; if (StoreCount !== 4'd2) begin fails++; $display("FAIL mis_str_count: got %0d want 2", StoreCount); end
        idle();
        checks++; if (AlignFault !== 1'b0) begin fails++; $display("FAIL mis_pulse_end: got %b want 0", AlignFault); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'd0);
        checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL mis_str_dropped: got %h want 00000000", ReadDataW); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_000A, 32'd0);
        checks++; if (ReadDataW !== 32'hDEAD_5AEF) begin fails++; $display("FAIL mis_ldr_data: got %h want dead5aef", ReadDataW); end
        checks++; if (AlignFault !== 1'b1) begin fails++; $display("FAIL mis_ldr_fault: got %b want 1", AlignFault); end
        access(1'b1, 1'b0, 1'b1, 32'h0000_000A, 32'd0);
        checks++; if (ReadDataW !== 32'h0000_00AD) begin fails++; $display("FAIL ldrb_lane2: got %h want 000000ad", ReadDataW); end
        checks++; if (AlignFault !== 1'b0) begin fails++; $display("FAIL ldrb_no_fault: got %b want 0", AlignFault); end
    endtask

    task automatic test_wrap_rbw();
        access(1'b0, 1'b1, 1'b0, 32'h0000_0104, 32'h0000_0001);
        checks++; if (StoreCount !== 4'd3) begin fails++; $display("FAIL wrap_count: got %0d want 3", StoreCount); end
        access(1'b1, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0002);
        checks++; if (ReadDataW !== 32'h0000_0001) begin fails++; $display("FAIL rbw_old: got %h want 00000001", ReadDataW); end
        checks++; if (StoreCount !== 4'd4) begin fails++; $display("FAIL rbw_count: got %0d want 4", StoreCount); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_0004, 32'd0);
        checks++; if (ReadDataW !== 32'h0000_0002) begin fails++; $display("FAIL rbw_new: got %h want 00000002", ReadDataW); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 11; i++) begin
            access(1'b0, 1'b1, 1'b0, 32'h0000_0014, i);
        end
        checks++; if (StoreCount !== 4'd15) begin fails++; $display("FAIL sat_reach: got %0d want 15", StoreCount); end
        access(1'b0, 1'b1, 1'b1, 32'h0000_0015, 32'h0000_0077);
        access(1'b0, 1'b1, 1'b0, 32'h0000_0014, 32'h0000_0099);
        checks++; if (StoreCount !== 4'd15) begin fails++; $display("FAIL sat_hold: got %0d want 15", StoreCount); end
        access(1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'd0);
        checks++; if (ReadDataW !== 32'h0000_0099) begin fails++; $display("FAIL sat_store_done: got %h want 00000099", ReadDataW); end
    endtask

    task automatic test_reset_midstream();
        int n;
        checks++; if (ReadDataW === 32'd0) begin fails++; $display("FAIL pre_reset_data: got %h want nonzero", ReadDataW); end
        MemReadM = 1'b1; MemWriteM = 1'b1; ByteM = 1'b0;
        ALUOutM = 32'h0000_0008; WriteDataM = 32'hFFFF_FFFF;
        #3;
        RESET_N = 1'b0;
        #1;
        checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL mid_rst_rdata: got %h want 00000000", ReadDataW); end
        checks++; if (Ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b want 0", Ready); end
        checks++; if (StoreCount !== 4'd0) begin fails++; $display("FAIL mid_rst_count: got %0d want 0", StoreCount); end
        idle();
        MemReadM = 1'b0; MemWriteM = 1'b0;
        RESET_N = 1'b1;
        n = 0;
        while (Ready !== 1'b1 && n < 200) begin
            if (n == 63) begin
                MemReadM = 1'b1; MemWriteM = 1'b1; ByteM = 1'b0;
                ALUOutM = 32'h0000_0000; WriteDataM = 32'hCAFE_F00D;
            end
            idle();
            MemReadM = 1'b0; MemWriteM = 1'b0;
            n++;
        end
        checks++; if (n != 64) begin fails++; $display("FAIL mid_clear_cycles: got %0d want 64", n); end
        checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL clear_ignore_load: got %h want 00000000", ReadDataW); end
        checks++; if (StoreCount !== 4'd0) begin fails++; $display("FAIL clear_ignore_count: got %0d want 0", StoreCount); end
        for (int i = 0; i < 64; i++) begin
            access(1'b1, 1'b0, 1'b0, i * 4, 32'd0);
            checks++; if (ReadDataW !== 32'd0) begin fails++; $display("FAIL cleared_word_%0d: got %h want 00000000", i, ReadDataW); end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_misaligned();
        test_wrap_rbw();
        test_saturate();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
